// File: rtl/lvds_rx_deframer.sv
// LVDS receive deframer: bitslip word alignment, training/sync detection,
// word assembly with idle-fill filtering, and a small output FIFO.
module lvds_rx_deframer #(
  parameter int                 WORD_W     = 32,
  parameter int                 LANE_W     = 8,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [LANE_W-1:0]  TRAIN_PAT  = LANE_W'(8'b00110101),
  parameter logic [LANE_W-1:0]  SYNC_PAT   = LANE_W'(8'b01110111),
  parameter int                 CONFIRM_N  = 6,
  parameter int                 MAX_SLIPS  = 16
) (
  input  logic              rx_outclock,
  input  logic              reset_n,
  input  logic              rx_locked,
  input  logic [LANE_W-1:0] rx_out,
  output logic              rx_data_align,
  output logic              rx_align_done,
  output logic              align_fail,
  output logic [WORD_W-1:0] deq_rx,
  output logic              EN_deq_rx,
  input  logic              RDY_deq_rx,
  output logic [7:0]        overflow_cnt,
  output logic [3:0]        led_state
);

  localparam int BEATS   = WORD_W / LANE_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int MATCH_W = $clog2(CONFIRM_N + 1);
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    SLIP    = 3'd2,
    SETTLE  = 3'd3,
    CONFIRM = 3'd4,
    SYNC    = 3'd5,
    DATA    = 3'd6,
    FAIL    = 3'd7
  } state_t;

  state_t              state;
  logic [SLIP_W-1:0]   slip_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                settle_cnt;
  logic [WORD_W-1:0]   shift_reg;

  logic [WORD_W-1:0]   word_next;
  logic                last_beat;
  logic                push;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_en;

  assign led_state = {1'b0, state};

  // First beat ends up in the MSBs because every new beat enters at the bottom.
  assign word_next = (shift_reg << LANE_W) | WORD_W'(rx_out);
  assign last_beat = (state == DATA) && (beat_cnt == BEAT_W'(BEATS - 1));
  assign push      = rx_locked && last_beat && word_next[WORD_W-1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the register values from before this edge.
  always_ff @(posedge rx_outclock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      slip_cnt      <= '0;
      match_cnt     <= '0;
      beat_cnt      <= '0;
      settle_cnt    <= 1'b0;
      shift_reg     <= '0;
      rx_data_align <= 1'b0;
      rx_align_done <= 1'b0;
      align_fail    <= 1'b0;
    end else begin
      rx_data_align <= 1'b0;
      if (!rx_locked) begin
        state         <= IDLE;
        rx_align_done <= 1'b0;
        align_fail    <= 1'b0;
        beat_cnt      <= '0;
        shift_reg     <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= HUNT;
            slip_cnt <= '0;
          end
          HUNT: begin
            if (rx_out == TRAIN_PAT) begin
              state     <= CONFIRM;
              match_cnt <= MATCH_W'(1);
            end else begin
              // Pulse is registered so it is high exactly while in SLIP.
              state         <= SLIP;
              rx_data_align <= 1'b1;
            end
          end
          SLIP: begin
            slip_cnt   <= slip_cnt + 1'b1;
            settle_cnt <= 1'b0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt) begin
              if (slip_cnt == SLIP_W'(MAX_SLIPS)) begin
                state      <= FAIL;
                align_fail <= 1'b1;
              end else begin
                state <= HUNT;
              end
            end else begin
              settle_cnt <= 1'b1;
            end
          end
          CONFIRM: begin
            if (rx_out == TRAIN_PAT) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_W'(CONFIRM_N - 1)) begin
                state         <= SYNC;
                rx_align_done <= 1'b1;
              end
            end else begin
              state <= HUNT;
            end
          end
          SYNC: begin
            if (rx_out == SYNC_PAT) begin
              state    <= DATA;
              beat_cnt <= '0;
            end else if (rx_out != TRAIN_PAT) begin
              state         <= HUNT;
              rx_align_done <= 1'b0;
            end
          end
          DATA: begin
            shift_reg <= word_next;
            beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
          end
          FAIL: begin
            state <= FAIL;
          end
        endcase
      end
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = !empty && RDY_deq_rx;
  assign EN_deq_rx = pop;
  assign wr_en     = push && (!full || pop);
  assign deq_rx    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, and deq_rx is masked while the FIFO is empty.
  always_ff @(posedge rx_outclock) begin
    if (wr_en) begin
      mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge rx_outclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Randomised scoreboard bench for lvds_rx_deframer: a reactive link model drives
// beats, expected words are queued at send time, and a monitor checks each dequeue.
module tb_lvds_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_locked = 1'b0;
  logic [7:0]  rx_out = 8'h00;
  logic        rdy = 1'b0;
  logic        rx_data_align;
  logic        rx_align_done;
  logic        align_fail;
  logic [31:0] deq_rx;
  logic        en_deq;
  logic [7:0]  overflow_cnt;
  logic [3:0]  led_state;

  lvds_rx_deframer dut (
    .rx_outclock   (clk),
    .reset_n       (rst_n),
    .rx_locked     (rx_locked),
    .rx_out        (rx_out),
    .rx_data_align (rx_data_align),
    .rx_align_done (rx_align_done),
    .align_fail    (align_fail),
    .deq_rx        (deq_rx),
    .EN_deq_rx     (en_deq),
    .RDY_deq_rx    (rdy),
    .overflow_cnt  (overflow_cnt),
    .led_state     (led_state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          exp_ovf = 0;
  int          pops = 0;
  int          slips = 0;
  int          dbl_pulse = 0;
  int          settle_run = 0;
  int          bad_settle = 0;
  logic        prev_align = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, bitslip pulse shape, SETTLE run lengths.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_align = 1'b0;
      settle_run = 0;
    end else begin
      if (rx_data_align) begin
        slips++;
        if (prev_align) dbl_pulse++;
      end
      prev_align = rx_data_align;
      if (led_state == 4'd3) begin
        settle_run++;
      end else begin
        if (settle_run != 0 && settle_run != 2) bad_settle++;
        settle_run = 0;
      end
      if (en_deq) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_deq: got %0h expected no transfer at %0t", deq_rx, $time);
        end else begin
          check("deq_word", deq_rx, exp_q.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [7:0] b);
    rx_out = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model of the output path: valid words (MSB set) are either
  // expected at the sink or counted as dropped, as decided by the test.
  task automatic send_word(input logic [31:0] w, input bit dropped);
    if (w[31]) begin
      if (dropped) begin
        if (exp_ovf < 255) exp_ovf++;
      end else begin
        exp_q.push_back(w);
      end
    end
    for (int i = 3; i >= 0; i--) beat(w[i*8 +: 8]);
  endtask

  task automatic align_clean();
    rx_locked = 1'b0;
    beat(8'h00);
    rx_locked = 1'b1;
    beat(8'h00);
    check("hunt_after_lock", led_state, 4'd1);
    repeat (5) beat(8'h35);
    check("done_before_6th", rx_align_done, 1'b0);
    beat(8'h35);
    check("done_after_6th", rx_align_done, 1'b1);
    check("state_sync", led_state, 4'd5);
    beat(8'h35);
    check("sync_holds_on_train", led_state, 4'd5);
    beat(8'h77);
    check("state_data", led_state, 4'd6);
  endtask

  task automatic drain();
    rdy = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) send_word(32'h0, 1'b0);
    send_word(32'h0, 1'b0);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic misaligned(input int k);
    rx_locked = 1'b0;
    beat(8'h00);
    slips = 0;
    dbl_pulse = 0;
    bad_settle = 0;
    rx_locked = 1'b1;
    for (int i = 0; i < 400 && !rx_align_done; i++) begin
      rx_out = (slips < k) ? 8'h6A : 8'h35;
      @(posedge clk);
      #1;
    end
    check("misalign_done", rx_align_done, 1'b1);
    check("misalign_slips", slips, k);
    check("misalign_single_pulse", dbl_pulse, 0);
    check("misalign_settle_len", bad_settle, 0);
    beat(8'h77);
    send_word(32'h8000_0000 | $urandom, 1'b0);
    drain();
  endtask

  initial begin
    logic [31:0] w;
    int          p0;

    // Reset state
    rdy = 1'b1;
    #12;
    check("rst_led", led_state, 4'd0);
    check("rst_done", rx_align_done, 1'b0);
    check("rst_fail", align_fail, 1'b0);
    check("rst_en", en_deq, 1'b0);
    check("rst_deq", deq_rx, 32'h0);
    check("rst_ovf", overflow_cnt, 8'h0);
    check("rst_slip", rx_data_align, 1'b0);
    rst_n = 1'b1;
    beat(8'h00);
    check("idle_no_lock", led_state, 4'd0);

    // Clean link, the reference word, an idle-fill word, then random words
    align_clean();
    send_word(32'h8122_3344, 1'b0);
    check("latency_en", en_deq, 1'b1);
    check("latency_deq", deq_rx, 32'h8122_3344);
    send_word(32'h7FFF_FFFF, 1'b0);
    for (int i = 0; i < 24; i++) send_word($urandom, 1'b0);
    drain();

    // Full FIFO with a pop on the same edge as the push
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h8000_0000 | $urandom, 1'b0);
    check("full_no_en", en_deq, 1'b0);
    w = 32'hC0DE_0000 | ($urandom & 32'hFFFF);
    exp_q.push_back(w);
    for (int i = 3; i >= 1; i--) beat(w[i*8 +: 8]);
    rdy = 1'b1;
    beat(w[7:0]);
    drain();
    check("simul_pop_no_ovf", overflow_cnt, exp_ovf);

    // Lock loss mid-word: partial discarded, buffered words kept
    rdy = 1'b0;
    send_word(32'h8000_0000 | $urandom, 1'b0);
    send_word(32'h8000_0000 | $urandom, 1'b0);
    beat(8'h99);
    beat(8'h88);
    rx_locked = 1'b0;
    beat(8'h77);
    check("lockloss_idle", led_state, 4'd0);
    check("lockloss_done", rx_align_done, 1'b0);
    align_clean();
    send_word(32'h8000_0000 | $urandom, 1'b0);
    drain();

    // Misaligned link
    misaligned(3);
    misaligned(int'($urandom_range(1, 10)));

    // Never aligns
    rx_locked = 1'b0;
    beat(8'h00);
    slips = 0;
    dbl_pulse = 0;
    rx_locked = 1'b1;
    for (int i = 0; i < 400 && !align_fail; i++) beat(8'h00);
    check("fail_slips", slips, 16);
    check("fail_flag", align_fail, 1'b1);
    check("fail_led", led_state, 4'd7);
    check("fail_done", rx_align_done, 1'b0);
    repeat (8) beat(8'h35);
    check("fail_sticky", led_state, 4'd7);
    check("fail_no_more_slips", slips, 16);
    check("fail_single_pulse", dbl_pulse, 0);
    rx_locked = 1'b0;
    beat(8'h00);
    check("fail_clear", align_fail, 1'b0);
    check("fail_to_idle", led_state, 4'd0);

    // Backpressure and overflow saturation
    align_clean();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) send_word(32'h8000_0000 | $urandom, i >= 4);
    check("bp_ovf2", overflow_cnt, exp_ovf);
    check("bp_no_en", en_deq, 1'b0);
    check("bp_head", deq_rx, exp_q[0]);
    for (int i = 0; i < 260; i++) send_word(32'h8000_0000 | $urandom, 1'b1);
    check("bp_ovf_sat", overflow_cnt, 8'hFF);
    p0 = pops;
    rdy = 1'b1;
    send_word(32'h0, 1'b0);
    check("bp_4_consecutive", pops - p0, 4);
    check("bp_empty_after", en_deq, 1'b0);
    drain();

    // Reset mid-word discards partial word and FIFO contents
    rdy = 1'b0;
    send_word(32'h8000_0000 | $urandom, 1'b0);
    send_word(32'h8000_0000 | $urandom, 1'b0);
    beat(8'hAA);
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    exp_ovf = 0;
    rdy = 1'b1;
    #1;
    check("rstmid_led", led_state, 4'd0);
    check("rstmid_en", en_deq, 1'b0);
    check("rstmid_deq", deq_rx, 32'h0);
    check("rstmid_ovf", overflow_cnt, 8'h0);
    check("rstmid_done", rx_align_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    align_clean();
    send_word(32'h8000_0000 | $urandom, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule
